simon_input_loader: RTL
=======================

// Module: simon_input_loader
// PURPOSE
// - Serial-to-parallel front end of the Simon32/64 datapath. It sits between the input pads and simon_newer.
// - Accepts an 8-beat burst in which every beat carries N key bits and M plaintext bits.
// - Assembles the 64-bit key and the 32-bit block, then pulses done. That pulse is simon_newer's start.
// PARAMETERS
// - N       8   key bits per beat
// - M       4   plaintext bits per beat
// - BEATS   8   beats per burst; both fields below must equal N*BEATS and M*BEATS
// - KEY_W   64  assembled key width
// - DATA_W  32  assembled plaintext width
// PORTS
// - clk       in   1       single clock; everything changes on the rising edge
// - reset     in   1       synchronous, active-low (0 = reset)
// - start     in   1       burst start; beat 0 is on key/Plaintxt in the same cycle
// - key       in   N       key beat
// - Plaintxt  in   M       plaintext beat
// - data      out  DATA_W  assembled plaintext, registered
// - key_out   out  KEY_W   assembled key, registered
// - done      out  1       one-cycle pulse: data/key_out just updated
// - busy      out  1       1 while a burst is being captured
// BEHAVIOUR
// - Reset (reset==0 at an edge):
//   - state=IDLE, beat counter=0, shift registers=0.
//   - data=0, key_out=0, done=0, busy=0.
//   - Reset has priority over everything and aborts a burst in progress.
//   - Partial shift contents are discarded and never reach the outputs.
// - FSM states: IDLE, LOAD, DONE.
//   - IDLE: start=1 at edge E0 captures beat 0, sets cnt=1 and goes to LOAD. start=0 stays in IDLE.
//   - LOAD: captures one beat per edge regardless of start.
//     - A start during LOAD is ignored; there is no restart.
//     - The edge capturing beat BEATS-1 goes to DONE.
//   - DONE: lasts one cycle.
//     - Goes to IDLE.
//     - If start=1 in this cycle, that cycle is beat 0 of a new burst and the next state is LOAD (back-to-back).
// - Capture order: MSB-first.
//   - Shift-left by N (key) and by M (text); the new beat enters the LSBs.
//   - So beat 0 ends in key_out[KEY_W-1 -: N] and data[DATA_W-1 -: M].
// - Output update:
//   - At the edge capturing the final beat (E0+BEATS-1), data and key_out load the complete words atomically and done goes to 1.
//   - done returns to 0 at the next edge.
//   - Outputs then hold their value until the next burst completes; they do not change while the next burst is loading.
// - Latency: done is high in the cycle after edge E0+7, which is 8 edges after start is sampled.
// - busy: high from the edge after E0 through the edge that enters DONE. It is 0 in IDLE and in DONE.
// - The beat counter is $clog2(BEATS) bits wide. It wraps to 0 on entry to DONE and never overflows.
// - No combinational path from any input to any output.
// TESTING
// - T1 reset, then one burst (Simon32/64 vector):
//   - key beats 19,18,11,10,09,08,01,00 (hex); text beats 6,5,6,5,6,8,7,7.
//   - Required: key_out=64'h1918111009080100, data=32'h65656877, done high for exactly 1 cycle, 8 edges after start.
// - T2 hold: after T1, idle for 20 cycles with random key/Plaintxt.
//   - Required: outputs unchanged and done=0.
// - T3 start held high for 20 cycles:
//   - Required: consecutive bursts, done every 8 cycles, no extra pulses.
//   - Required: the 2nd burst's value appears only at its own done.
// - T4 reset pulsed low after beat 4:
//   - Required: outputs 0 and busy 0 next cycle.
//   - Required: a fresh burst then yields its correct value with no residue from the aborted one.
// - T5 start=1 during LOAD (beat 3):
//   - Required: ignored; the burst completes with its original timing and value.
// - T6 back-to-back: start=1 exactly in the DONE cycle with a second vector (all-ones key, text 32'hA5A5A5A5).
//   - Required: second done 8 cycles after the first, with those values.

Source files
------------

// File: rtl/simon_input_loader_if.sv
// Beat-level input and assembled-word output bundle of the Simon32/64 input loader.
// The master side presents one key/plaintext beat per cycle.
// The slave side returns the assembled key/block plus the done/busy status.
interface simon_input_loader_if #(
    parameter int N      = 8,
    parameter int M      = 4,
    parameter int KEY_W  = 64,
    parameter int DATA_W = 32
);
    logic              start;
    logic [N-1:0]      key;
    logic [M-1:0]      Plaintxt;
    logic [DATA_W-1:0] data;
    logic [KEY_W-1:0]  key_out;
    logic              done;
    logic              busy;

    modport master (
        output start, key, Plaintxt,
        input  data, key_out, done, busy
    );

    modport slave (
        input  start, key, Plaintxt,
        output data, key_out, done, busy
    );
endinterface

// File: rtl/simon_input_loader.sv
// Serial-to-parallel front end of the Simon32/64 datapath.
// Collects an MSB-first burst of BEATS beats and publishes the 64-bit key and
// the 32-bit block atomically, together with a one-cycle done pulse that
// serves as the cipher core's start.
module simon_input_loader #(
    parameter int N      = 8,
    parameter int M      = 4,
    parameter int BEATS  = 8,
    parameter int KEY_W  = 64,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    simon_input_loader_if.slave   bus
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [KEY_W-1:0]   key_sr_r;
    logic [DATA_W-1:0]  data_sr_r;
    logic [KEY_W-1:0]   key_out_r;
    logic [DATA_W-1:0]  data_r;
    logic               done_r;
    logic               busy_r;

    // Shift-register contents after accepting the beat currently on the bus.
    logic [KEY_W-1:0]   key_next_s;
    logic [DATA_W-1:0]  data_next_s;

    assign key_next_s  = {key_sr_r[KEY_W-N-1:0], bus.key};
    assign data_next_s = {data_sr_r[DATA_W-M-1:0], bus.Plaintxt};

    // Burst sequencer: beat capture, completion publish and status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            key_sr_r  <= {KEY_W{1'b0}};
            data_sr_r <= {DATA_W{1'b0}};
            key_out_r <= {KEY_W{1'b0}};
            data_r    <= {DATA_W{1'b0}};
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                // DONE behaves like IDLE so a start in the done cycle
                // opens the next burst without a gap.
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        key_sr_r  <= {{(KEY_W-N){1'b0}}, bus.key};
                        data_sr_r <= {{(DATA_W-M){1'b0}}, bus.Plaintxt};
                        cnt_r     <= CNT_ONE;
                        state_r   <= ST_LOAD;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                    end
                end
                // One beat per edge; start is ignored until the burst ends.
                ST_LOAD: begin
                    key_sr_r  <= key_next_s;
                    data_sr_r <= data_next_s;
                    if (cnt_r == LAST_BEAT) begin
                        key_out_r <= key_next_s;
                        data_r    <= data_next_s;
                        done_r    <= 1'b1;
                        cnt_r     <= CNT_ZERO;
                        state_r   <= ST_DONE;
                        busy_r    <= 1'b0;
                    end else begin
                        cnt_r     <= cnt_r + CNT_ONE;
                        state_r   <= ST_LOAD;
                        busy_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data    = data_r;
    assign bus.key_out = key_out_r;
    assign bus.done    = done_r;
    assign bus.busy    = busy_r;
endmodule
